data_write_buffer: RTL
======================

// Module: data_write_buffer
// PURPOSE
// - Posted-write FIFO on the data sram-like path, between the cached/uncached data merge and the AXI interface's data port.
// - Stores are acknowledged upstream without waiting for the AXI write response.
// - Reads are held until every buffered store has completed downstream, so memory ordering is preserved.
// - Reads pass through one at a time.
// PARAMETERS
// DEPTH      8   FIFO entries; power of 2, >=2
// PTR_W      3   log2(DEPTH)
// PORTS
// clk          in   1   clock
// resetn       in   1   asynchronous, active-low reset
// up_req       in   1   upstream request
// up_wr        in   1   1=write, 0=read
// up_size      in   2   0=byte, 1=half, 2=word
// up_addr      in   32  physical address
// up_wdata     in   32  store data
// up_rdata     out  32  load data
// up_addr_ok   out  1   request accepted
// up_data_ok   out  1   transaction complete
// dn_req       out  1   downstream request
// dn_wr        out  1   downstream write flag
// dn_size      out  2   downstream size
// dn_addr      out  32  downstream address
// dn_wdata     out  32  downstream store data
// dn_rdata     in   32  downstream load data
// dn_addr_ok   in   1   downstream accept
// dn_data_ok   in   1   downstream complete; never in the same cycle as its dn_addr_ok
// wb_empty     out  1   FIFO empty and no downstream write in flight
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low.
// - Reset values:
//   - Outputs: up_addr_ok=0, up_data_ok=0, dn_req=0, dn_wr=0, wb_empty=1, all data/addr outputs 0.
//   - State: FIFO pointers and count=0, FSM=IDLE.
// - Reset mid-transaction: in-flight and buffered stores are discarded. Reset must be system-wide.
// - Entry format: {size[1:0], addr[31:0], wdata[31:0]}. count is PTR_W+1 bits; pointers wrap modulo DEPTH.
// - Write accept (combinational): up_addr_ok = up_req & up_wr & (count!=DEPTH) & ~rd_busy.
//   - Push happens on the accept cycle.
//   - up_data_ok pulses exactly 1 cycle after each accepted write; up_rdata is don't-care on that pulse.
// - Read accept (combinational): up_addr_ok = up_req & ~up_wr & (count==0) & (fsm==IDLE).
//   - On accept: capture size/addr into read regs, set rd_busy, FSM->RD_ADDR.
//   - While rd_busy, no upstream request of either kind is accepted.
// - Downstream FSM:
//   - IDLE: if rd_busy -> RD_ADDR; else if count!=0 -> WR_ADDR.
//   - WR_ADDR: dn_req=1, dn_wr=1, head-entry fields driven. On dn_addr_ok -> WR_WAIT.
//   - WR_WAIT: dn_req=0. On dn_data_ok: pop head -> IDLE.
//   - RD_ADDR: dn_req=1, dn_wr=0, read regs driven. On dn_addr_ok -> RD_WAIT.
//   - RD_WAIT: on dn_data_ok: up_data_ok=1 and up_rdata=dn_rdata (same cycle, combinational), clear rd_busy -> IDLE.
// - Head entry is held until its dn_data_ok. dn_* stay stable while dn_req=1 without dn_addr_ok.
// - Push and pop in the same cycle: count is unchanged, both pointers advance.
//   - Full is judged on registered count: no bypass, no push when full even if popping.
// - Empty FIFO: no write bypass. A store reaches dn_req at the earliest 1 cycle after its accept.
// - Read latency: accept at t -> dn_req at t+1 -> up_data_ok in the same cycle as dn_data_ok.
// - The up_data_ok write-ack pulse and a read completion never coincide: reads are only accepted with count==0, one cycle after any write ack.
// - wb_empty = (count==0) & (fsm!=WR_ADDR) & (fsm!=WR_WAIT).
// TESTING
// - Reset with up_req=1 -> all outputs at reset values. Release -> first write accepted the cycle it is presented.
// - 8 back-to-back writes A0..A7 with dn_addr_ok held 0:
//   - all 8 accepted, up_data_ok on 8 consecutive cycles.
//   - 9th write stalls with up_addr_ok=0.
//   - after first dn_data_ok, 9th write accepted next cycle.
// - Write 0x1000<=0xDEAD then read 0x1000:
//   - read not accepted until the write's dn_data_ok.
//   - then dn_req read issued, up_rdata returns downstream value.
// - Downstream with random 0-5 cycle addr_ok/data_ok delays, 1000 mixed ops:
//   - downstream order equals upstream order.
//   - every write reaches dn_* with exact size/addr/wdata.
// - Full FIFO, push attempt in the same cycle as a pop: push refused, count 8->7, accepted next cycle.
// - Assert resetn while in WR_WAIT with 3 entries: wb_empty=1 immediately, dn_req=0, no further downstream writes.

Source files
------------

// File: rtl/data_write_buffer.sv
// data_write_buffer: posted-write FIFO between the data merge and the AXI data port.
// Stores are acked at once; loads wait until every buffered store has drained.
module data_write_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        up_req,
  input  logic        up_wr,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  output logic        up_addr_ok,
  output logic        up_data_ok,
  output logic        dn_req,
  output logic        dn_wr,
  output logic [1:0]  dn_size,
  output logic [31:0] dn_addr,
  output logic [31:0] dn_wdata,
  input  logic [31:0] dn_rdata,
  input  logic        dn_addr_ok,
  input  logic        dn_data_ok,
  output logic        wb_empty
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_WAIT, RD_ADDR, RD_WAIT
  } state_e;

  localparam int EW = 66;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             rd_busy_q, wack_q;
  logic [1:0]       rsize_q;
  logic [31:0]      raddr_q;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic             push, pop, rd_done;
  logic [EW-1:0]    head;

  assign full  = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;

  // resetn gates the accepts so nothing is taken while held in reset
  assign wr_acc = resetn & up_req & up_wr & ~full & ~rd_busy_q;
  assign rd_acc = resetn & up_req & ~up_wr & empty & ~rd_busy_q
                & (state_q == IDLE);

  assign up_addr_ok = wr_acc | rd_acc;
  assign push       = wr_acc;
  assign pop        = (state_q == WR_WAIT) & dn_data_ok;
  assign head       = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {up_size, up_addr, up_wdata};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rd_busy_q <= 1'b0;
      wack_q    <= 1'b0;
      rsize_q   <= '0;
      raddr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wack_q  <= wr_acc;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (rd_acc) begin
        rd_busy_q <= 1'b1;
        rsize_q   <= up_size;
        raddr_q   <= up_addr;
      end else if (rd_done) begin
        rd_busy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dn_req   = 1'b0;
    dn_wr    = 1'b0;
    dn_size  = '0;
    dn_addr  = '0;
    dn_wdata = '0;
    up_rdata = '0;
    rd_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_acc || rd_busy_q) state_d = RD_ADDR;
        else if (!empty)         state_d = WR_ADDR;
      end
      WR_ADDR: begin
        dn_req = 1'b1;
        dn_wr  = 1'b1;
        {dn_size, dn_addr, dn_wdata} = head;
        if (dn_addr_ok) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (dn_data_ok) state_d = IDLE;
      end
      RD_ADDR: begin
        dn_req  = 1'b1;
        dn_size = rsize_q;
        dn_addr = raddr_q;
        if (dn_addr_ok) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (dn_data_ok) begin
          rd_done  = 1'b1;
          up_rdata = dn_rdata;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign up_data_ok = wack_q | rd_done;
  assign wb_empty   = empty & (state_q != WR_ADDR) & (state_q != WR_WAIT);

endmodule
